reg_status: RTL and testbench



---
 rtl/reg_status_pkg.sv | 36 +++
 rtl/reg_status_lookup.sv | 24 ++
 rtl/reg_status.sv | 95 +++++++++
 tb/tb_reg_status.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/reg_status_pkg.sv
// reg_status_pkg: shared widths and port bundles for the commit-side register status table.
package reg_status_pkg;
    localparam int XLEN           = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int TAG_WIDTH      = 3;
    localparam int NREGS          = 1 << REG_ADDR_WIDTH;

    typedef logic [XLEN-1:0]           word_t;
    typedef logic [REG_ADDR_WIDTH-1:0] addr_t;
    typedef logic [TAG_WIDTH-1:0]      tag_t;

    typedef struct packed {
        logic  stall;
        logic  flush;
        logic  issue_en;
        addr_t issue_rd;
        tag_t  issue_tag;
        addr_t rs1_addr;
        addr_t rs2_addr;
        logic  commit_en;
        addr_t commit_dest;
        word_t commit_value;
        tag_t  commit_tag;
    } reg_status_in;

    typedef struct packed {
        logic  busy;
        tag_t  tag;
        word_t value;
    } lookup_out_t;

    typedef struct packed {
        lookup_out_t rs1;
        lookup_out_t rs2;
    } reg_status_out;
endpackage

// File: rtl/reg_status_lookup.sv
// regstat_lookup: one source-operand read of the status table, bypassing the retiring value
// when the head commit is exactly the producer this register is waiting on.
module regstat_lookup
    import reg_status_pkg::*;
(
    input  logic        rs_addr_i_unused_guard,
    input  addr_t       rs_addr_i,
    input  logic        busy_i,
    input  tag_t        tag_i,
    input  word_t       value_i,
    input  logic        stall_i,
    input  logic        commit_en_i,
    input  addr_t       commit_dest_i,
    input  tag_t        commit_tag_i,
    input  word_t       commit_value_i,
    output lookup_out_t res_o
);
    logic byp;
    assign byp = commit_en_i && !stall_i && commit_dest_i == rs_addr_i && busy_i && tag_i == commit_tag_i
                 && !rs_addr_i_unused_guard;
    assign res_o.busy  = busy_i && !byp;
    assign res_o.tag   = res_o.busy ? tag_i : '0;
    assign res_o.value = byp ? commit_value_i : value_i;
endmodule

// File: rtl/reg_status.sv
// reg_status: architected register file plus rename/busy table, written by the ROB commit
// stream and answering issue-stage operand lookups with either a value or a producer tag.
module reg_status
    import reg_status_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        issue_en_i,
    input  addr_t       issue_rd_i,
    input  tag_t        issue_tag_i,
    input  addr_t       rs1_addr_i,
    input  addr_t       rs2_addr_i,
    input  logic        commit_en_i,
    input  addr_t       commit_dest_i,
    input  word_t       commit_value_i,
    input  tag_t        commit_tag_i,
    output logic        rs1_busy_o,
    output tag_t        rs1_tag_o,
    output word_t       rs1_value_o,
    output logic        rs2_busy_o,
    output tag_t        rs2_tag_o,
    output word_t       rs2_value_o
);
    reg_status_in  in_s;
    reg_status_out out_s;
    word_t             val_q [NREGS];
    word_t             val_d [NREGS];
    tag_t              tag_q [NREGS];
    tag_t              tag_d [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;

    assign in_s = '{stall: stall_i, flush: flush_i, issue_en: issue_en_i, issue_rd: issue_rd_i,
                    issue_tag: issue_tag_i, rs1_addr: rs1_addr_i, rs2_addr: rs2_addr_i,
                    commit_en: commit_en_i, commit_dest: commit_dest_i,
                    commit_value: commit_value_i, commit_tag: commit_tag_i};

    // Entry 0 is never written, so x0 always reads as value 0 and not busy.
    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (!in_s.stall) begin
            for (int i = 1; i < NREGS; i++) begin
                if (in_s.commit_en && in_s.commit_dest == addr_t'(i)) begin
                    val_d[i] = in_s.commit_value;
                    if (busy_q[i] && tag_q[i] == in_s.commit_tag) busy_d[i] = 1'b0;
                end
                if (in_s.issue_en && in_s.issue_rd == addr_t'(i)) begin
                    busy_d[i] = 1'b1;
                    tag_d[i]  = in_s.issue_tag;
                end
            end
            if (in_s.flush) busy_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            val_q  <= val_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

    regstat_lookup u_rs1 (
        .rs_addr_i_unused_guard(1'b0),
        .rs_addr_i(in_s.rs1_addr), .busy_i(busy_q[in_s.rs1_addr]), .tag_i(tag_q[in_s.rs1_addr]),
        .value_i(val_q[in_s.rs1_addr]), .stall_i(in_s.stall), .commit_en_i(in_s.commit_en),
        .commit_dest_i(in_s.commit_dest), .commit_tag_i(in_s.commit_tag),
        .commit_value_i(in_s.commit_value), .res_o(out_s.rs1)
    );

    regstat_lookup u_rs2 (
        .rs_addr_i_unused_guard(1'b0),
        .rs_addr_i(in_s.rs2_addr), .busy_i(busy_q[in_s.rs2_addr]), .tag_i(tag_q[in_s.rs2_addr]),
        .value_i(val_q[in_s.rs2_addr]), .stall_i(in_s.stall), .commit_en_i(in_s.commit_en),
        .commit_dest_i(in_s.commit_dest), .commit_tag_i(in_s.commit_tag),
        .commit_value_i(in_s.commit_value), .res_o(out_s.rs2)
    );

    assign rs1_busy_o  = out_s.rs1.busy;
    assign rs1_tag_o   = out_s.rs1.tag;
    assign rs1_value_o = out_s.rs1.value;
    assign rs2_busy_o  = out_s.rs2.busy;
    assign rs2_tag_o   = out_s.rs2.tag;
    assign rs2_value_o = out_s.rs2.value;
endmodule

// File: tb/tb_reg_status.sv
// tb_reg_status: directed scenarios with literal expectations, then random traffic checked
// every negative edge against a behavioural register/busy/tag model.
module tb_reg_status;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0, flush_i = 1'b0, issue_en_i = 1'b0, commit_en_i = 1'b0;
    logic [4:0]  issue_rd_i = '0, rs1_addr_i = '0, rs2_addr_i = '0, commit_dest_i = '0;
    logic [2:0]  issue_tag_i = '0, commit_tag_i = '0;
    logic [31:0] commit_value_i = '0;
    logic        rs1_busy_o, rs2_busy_o;
    logic [2:0]  rs1_tag_o, rs2_tag_o;
    logic [31:0] rs1_value_o, rs2_value_o;

    logic [31:0] m_val  [32] = '{default: '0};
    logic        m_busy [32] = '{default: 1'b0};
    logic [2:0]  m_tag  [32] = '{default: '0};
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reg_status dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .issue_en_i(issue_en_i), .issue_rd_i(issue_rd_i), .issue_tag_i(issue_tag_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .commit_en_i(commit_en_i), .commit_dest_i(commit_dest_i),
        .commit_value_i(commit_value_i), .commit_tag_i(commit_tag_i),
        .rs1_busy_o(rs1_busy_o), .rs1_tag_o(rs1_tag_o), .rs1_value_o(rs1_value_o),
        .rs2_busy_o(rs2_busy_o), .rs2_tag_o(rs2_tag_o), .rs2_value_o(rs2_value_o)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    // Expected lookup from the architectural model plus the retiring head entry.
    task automatic look(input string nm, input logic [4:0] rs, input logic b,
                        input logic [2:0] t, input logic [31:0] v);
        logic        eb;
        logic [31:0] ev;
        if (rs == 0) begin
            eb = 1'b0; ev = '0;
        end else if (commit_en_i && !stall_i && commit_dest_i == rs && m_busy[rs] && m_tag[rs] == commit_tag_i) begin
            eb = 1'b0; ev = commit_value_i;
        end else begin
            eb = m_busy[rs]; ev = m_val[rs];
        end
        chk({nm, "_busy"}, {31'b0, b}, {31'b0, eb});
        if (eb) chk({nm, "_tag"}, {29'b0, t}, {29'b0, m_tag[rs]});
        else    chk({nm, "_value"}, v, ev);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
        end else if (!stall_i) begin
            if (commit_en_i && commit_dest_i != 0) begin
                m_val[commit_dest_i] = commit_value_i;
                if (m_busy[commit_dest_i] && m_tag[commit_dest_i] == commit_tag_i) m_busy[commit_dest_i] = 1'b0;
            end
            if (issue_en_i && issue_rd_i != 0) begin
                m_busy[issue_rd_i] = 1'b1;
                m_tag[issue_rd_i]  = issue_tag_i;
            end
            if (flush_i) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        look("rs1", rs1_addr_i, rs1_busy_o, rs1_tag_o, rs1_value_o);
        look("rs2", rs2_addr_i, rs2_busy_o, rs2_tag_o, rs2_value_o);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_en_i = 0; commit_en_i = 0; flush_i = 0; stall_i = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rs1_addr_i = 5; rs2_addr_i = 0; #1;
        chk("rst_rs1_busy", {31'b0, rs1_busy_o}, 0); chk("rst_rs1_val", rs1_value_o, 0);
        chk("rst_rs2_busy", {31'b0, rs2_busy_o}, 0); chk("rst_rs2_val", rs2_value_o, 0);
        issue_en_i = 1; issue_rd_i = 5; issue_tag_i = 3; step(); idle(); #1;
        chk("ren_busy", {31'b0, rs1_busy_o}, 1); chk("ren_tag", {29'b0, rs1_tag_o}, 3);
        commit_en_i = 1; commit_dest_i = 5; commit_tag_i = 3; commit_value_i = 32'hDEADBEEF; #1;
        chk("byp_busy", {31'b0, rs1_busy_o}, 0); chk("byp_val", rs1_value_o, 32'hDEADBEEF);
        step(); idle(); #1;
        chk("st_busy", {31'b0, rs1_busy_o}, 0); chk("st_val", rs1_value_o, 32'hDEADBEEF);
        issue_en_i = 1; issue_rd_i = 7; issue_tag_i = 1; step();
        issue_tag_i = 2; step(); idle();
        commit_en_i = 1; commit_dest_i = 7; commit_tag_i = 1; commit_value_i = 32'h11; rs1_addr_i = 7; #1;
        chk("stale_nobyp", {31'b0, rs1_busy_o}, 1);
        step(); idle(); #1;
        chk("stale_busy", {31'b0, rs1_busy_o}, 1); chk("stale_tag", {29'b0, rs1_tag_o}, 2);
        commit_en_i = 1; commit_tag_i = 2; commit_value_i = 32'h22; step(); idle(); #1;
        chk("young_busy", {31'b0, rs1_busy_o}, 0); chk("young_val", rs1_value_o, 32'h22);
        issue_en_i = 1; issue_rd_i = 9; issue_tag_i = 0; step();
        issue_tag_i = 4; commit_en_i = 1; commit_dest_i = 9; commit_tag_i = 0; commit_value_i = 32'h55;
        rs1_addr_i = 9; step(); idle(); #1;
        chk("rw_busy", {31'b0, rs1_busy_o}, 1); chk("rw_tag", {29'b0, rs1_tag_o}, 4);
        issue_en_i = 1; issue_rd_i = 3; issue_tag_i = 5; step();
        issue_rd_i = 4; issue_tag_i = 6; step(); idle();
        flush_i = 1; commit_en_i = 1; commit_dest_i = 3; commit_tag_i = 7; commit_value_i = 32'h77;
        rs1_addr_i = 3; rs2_addr_i = 4; step(); idle(); #1;
        chk("fl_rs1_busy", {31'b0, rs1_busy_o}, 0); chk("fl_rs1_val", rs1_value_o, 32'h77);
        chk("fl_rs2_busy", {31'b0, rs2_busy_o}, 0);
        rs1_addr_i = 9; #1;
        chk("fl_x9_busy", {31'b0, rs1_busy_o}, 0); chk("fl_x9_val", rs1_value_o, 32'h55);
        issue_en_i = 1; issue_rd_i = 0; issue_tag_i = 1;
        commit_en_i = 1; commit_dest_i = 0; commit_value_i = 32'hFF; rs1_addr_i = 0; step(); idle(); #1;
        chk("x0_busy", {31'b0, rs1_busy_o}, 0); chk("x0_val", rs1_value_o, 0);
        issue_en_i = 1; issue_rd_i = 6; issue_tag_i = 2; step(); idle();
        stall_i = 1; commit_en_i = 1; commit_dest_i = 6; commit_tag_i = 2; commit_value_i = 32'hAB;
        issue_en_i = 1; issue_rd_i = 6; issue_tag_i = 5; rs1_addr_i = 6; #1;
        chk("stall_nobyp", {31'b0, rs1_busy_o}, 1); chk("stall_tag", {29'b0, rs1_tag_o}, 2);
        step(); idle(); #1;
        chk("stall_hold", {31'b0, rs1_busy_o}, 1); chk("stall_hold_tag", {29'b0, rs1_tag_o}, 2);
        commit_en_i = 1; commit_value_i = 32'hCD; step(); idle(); #1;
        chk("unstall_val", rs1_value_o, 32'hCD);
        issue_en_i = 1; issue_rd_i = 5; issue_tag_i = 1; step(); idle();
        rs1_addr_i = 5; rs2_addr_i = 9; #1;
        chk("pre_arst", {31'b0, rs1_busy_o}, 1);
        rst_n = 0; #1;
        chk("arst_busy", {31'b0, rs1_busy_o}, 0); chk("arst_val", rs1_value_o, 0);
        chk("arst_x9", rs2_value_o, 0);
        rst_n = 1;
        for (int k = 0; k < 500; k++) begin
            step();
            issue_en_i     = 1'($urandom_range(1));
            issue_rd_i     = 5'($urandom_range(7));
            issue_tag_i    = 3'($urandom);
            commit_en_i    = 1'($urandom_range(1));
            commit_dest_i  = 5'($urandom_range(7));
            commit_tag_i   = ($urandom_range(3) != 0) ? m_tag[commit_dest_i] : 3'($urandom);
            commit_value_i = $urandom;
            stall_i        = ($urandom_range(7) == 0);
            flush_i        = ($urandom_range(15) == 0);
            rs1_addr_i     = 5'($urandom_range(7));
            rs2_addr_i     = 5'($urandom_range(7));
        end
        step(); idle(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
